// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared opcode, field-width and status types for the TPU instruction sequencer
package tpu_pkg;

    localparam int INSTR_W = 32;
    localparam int OPC_W   = 6;
    localparam int ARG_W   = 26;

    localparam logic [OPC_W-1:0] OP_NOP    = 6'h00;
    localparam logic [OPC_W-1:0] OP_MATMUL = 6'h01;
    localparam logic [OPC_W-1:0] OP_VPU    = 6'h02;
    localparam logic [OPC_W-1:0] OP_UBMOVE = 6'h03;
    localparam logic [OPC_W-1:0] OP_HALT   = 6'h3F;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_PC_END  = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_ISSUE,
        S_WAIT_DONE,
        S_DONE,
        S_ERROR
    } seq_state_e;

    function automatic logic is_unit_op(input logic [OPC_W-1:0] op);
        return (op == OP_MATMUL) || (op == OP_VPU) || (op == OP_UBMOVE);
    endfunction

endpackage

// File: rtl/tpu_instr_sequencer_if.sv
// rtl/tpu_instr_sequencer_if.sv - instruction-buffer read port and datapath unit dispatch bundle
interface tpu_instr_sequencer_if #(
    parameter int PC_W = 5
) ();

    logic                       instr_rd_en;
    logic [PC_W-1:0]            instr_rd_addr;
    logic [tpu_pkg::INSTR_W-1:0] instr_rd_data;

    logic                       sys_start;
    logic                       vpu_start;
    logic                       ub_start;
    logic [tpu_pkg::ARG_W-1:0]  unit_arg;

    logic                       sys_done;
    logic                       vpu_done;
    logic                       ub_done;

    modport seq (
        output instr_rd_en, instr_rd_addr,
        input  instr_rd_data,
        output sys_start, vpu_start, ub_start, unit_arg,
        input  sys_done, vpu_done, ub_done
    );

    modport dp (
        input  instr_rd_en, instr_rd_addr,
        output instr_rd_data,
        input  sys_start, vpu_start, ub_start, unit_arg,
        output sys_done, vpu_done, ub_done
    );

endinterface

// File: rtl/tpu_instr_sequencer.sv
// rtl/tpu_instr_sequencer.sv - fetches, decodes and dispatches TPU instructions one at a time
module tpu_instr_sequencer
    import tpu_pkg::*;
#(
    parameter int IMEM_DEPTH     = 32,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    tpu_instr_sequencer_if.seq            bus,
    output logic                          seq_busy,
    output logic                          seq_done,
    output logic                          seq_error,
    output logic [1:0]                    err_code,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc
);

    localparam int PC_W  = $clog2(IMEM_DEPTH);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(IMEM_DEPTH - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    seq_state_e         state;
    err_code_e          err;
    logic [INSTR_W-1:0] instr;
    logic [TMR_W-1:0]   timer;
    logic [OPC_W-1:0]   opcode;
    logic               unit_done;
    logic               at_last;

    assign opcode            = instr[INSTR_W-1 -: OPC_W];
    assign at_last           = (pc == PC_LAST);
    assign err_code          = err;
    assign bus.instr_rd_addr = pc;

    // The instruction register still holds the issued opcode, so it selects whose done counts.
    always_comb begin
        unit_done = 1'b0;
        case (opcode)
            OP_MATMUL: unit_done = bus.sys_done;
            OP_VPU:    unit_done = bus.vpu_done;
            OP_UBMOVE: unit_done = bus.ub_done;
            default:   unit_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            err             <= ERR_NONE;
            instr           <= '0;
            timer           <= '0;
            pc              <= '0;
            seq_busy        <= 1'b0;
            seq_done        <= 1'b0;
            seq_error       <= 1'b0;
            bus.instr_rd_en <= 1'b0;
            bus.sys_start   <= 1'b0;
            bus.vpu_start   <= 1'b0;
            bus.ub_start    <= 1'b0;
            bus.unit_arg    <= '0;
        end else begin
            bus.instr_rd_en <= 1'b0;
            bus.sys_start   <= 1'b0;
            bus.vpu_start   <= 1'b0;
            bus.ub_start    <= 1'b0;

            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        pc              <= '0;
                        seq_done        <= 1'b0;
                        seq_error       <= 1'b0;
                        err             <= ERR_NONE;
                        seq_busy        <= 1'b1;
                        bus.instr_rd_en <= 1'b1;
                        state           <= S_FETCH;
                    end
                end

                S_FETCH: state <= S_LATCH;

                S_LATCH: begin
                    instr <= bus.instr_rd_data;
                    state <= S_ISSUE;
                end

                S_ISSUE: begin
                    if (opcode == OP_NOP) begin
                        if (at_last) begin
                            err       <= ERR_PC_END;
                            seq_error <= 1'b1;
                            seq_busy  <= 1'b0;
                            state     <= S_ERROR;
                        end else begin
                            pc              <= pc + 1'b1;
                            bus.instr_rd_en <= 1'b1;
                            state           <= S_FETCH;
                        end
                    end else if (opcode == OP_HALT) begin
                        seq_done <= 1'b1;
                        seq_busy <= 1'b0;
                        state    <= S_DONE;
                    end else if (is_unit_op(opcode)) begin
                        bus.unit_arg  <= instr[ARG_W-1:0];
                        bus.sys_start <= (opcode == OP_MATMUL);
                        bus.vpu_start <= (opcode == OP_VPU);
                        bus.ub_start  <= (opcode == OP_UBMOVE);
                        timer         <= '0;
                        state         <= S_WAIT_DONE;
                    end else begin
                        err       <= ERR_ILLEGAL;
                        seq_error <= 1'b1;
                        seq_busy  <= 1'b0;
                        state     <= S_ERROR;
                    end
                end

                // Done is tested first so it wins over a coincident timer expiry.
                S_WAIT_DONE: begin
                    if (unit_done) begin
                        if (at_last) begin
                            err       <= ERR_PC_END;
                            seq_error <= 1'b1;
                            seq_busy  <= 1'b0;
                            state     <= S_ERROR;
                        end else begin
                            pc              <= pc + 1'b1;
                            bus.instr_rd_en <= 1'b1;
                            state           <= S_FETCH;
                        end
                    end else if (timer == TMR_LAST) begin
                        err       <= ERR_TIMEOUT;
                        seq_error <= 1'b1;
                        seq_busy  <= 1'b0;
                        state     <= S_ERROR;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: begin
                    seq_busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_instr_sequencer.sv
// tb/tb_tpu_instr_sequencer.sv - scoreboard bench for the TPU instruction sequencer
module tb_tpu_instr_sequencer;
    import tpu_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       seq_busy;
    logic       seq_done;
    logic       seq_error;
    logic [1:0] err_code;
    logic [4:0] pc;

    tpu_instr_sequencer_if #(.PC_W(5)) bus ();

    tpu_instr_sequencer #(
        .IMEM_DEPTH     (32),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .seq_busy  (seq_busy),
        .seq_done  (seq_done),
        .seq_error (seq_error),
        .err_code  (err_code),
        .pc        (pc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [31:0] imem [32];
    always @(posedge clk) if (bus.instr_rd_en) bus.instr_rd_data <= imem[bus.instr_rd_addr];

    // Unit model: answers a start with done 5 cycles later when enabled; also injects stray vpu_done.
    int resp_en   = 0;
    int resp_cnt  = 0;
    int resp_unit = 0;
    int inj_req   = 0;
    int inj_ack   = 0;
    always @(posedge clk) begin
        #1;
        bus.sys_done = 1'b0;
        bus.vpu_done = 1'b0;
        bus.ub_done  = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt = resp_cnt - 1;
            if (resp_cnt == 0) begin
                if (resp_unit == 1) bus.sys_done = 1'b1;
                if (resp_unit == 2) bus.vpu_done = 1'b1;
                if (resp_unit == 3) bus.ub_done  = 1'b1;
            end
        end
        if (resp_en != 0 && resp_cnt == 0) begin
            if (bus.sys_start) begin resp_cnt = 5; resp_unit = 1; end
            if (bus.vpu_start) begin resp_cnt = 5; resp_unit = 2; end
            if (bus.ub_start)  begin resp_cnt = 5; resp_unit = 3; end
        end
        if (inj_req != inj_ack) begin
            bus.vpu_done = 1'b1;
            inj_ack = inj_req;
        end
    end

    // kind: 0 read (val=addr), 1 sys start, 2 vpu start, 3 ub start (val=unit_arg); cyc<0 = any
    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;
    ev_t exp_q[$];

    task automatic expect_ev(input int k, input int v, input int c);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic mon_compare(input int k, input int v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event_unexpected got kind=%0d val=%0h cyc=%0d required no event", k, v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v || (e.cyc >= 0 && e.cyc != cyc)) begin
                errors++;
                $display("FAIL event got kind=%0d val=%0h cyc=%0d required kind=%0d val=%0h cyc=%0d",
                         k, v, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.instr_rd_en) mon_compare(0, int'(bus.instr_rd_addr));
            if (bus.sys_start)   mon_compare(1, int'(bus.unit_arg));
            if (bus.vpu_start)   mon_compare(2, int'(bus.unit_arg));
            if (bus.ub_start)    mon_compare(3, int'(bus.unit_arg));
        end
    end

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got %0h required %0h (cyc %0d)", name, got, req, cyc);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(output int n);
        start = 1'b1;
        n     = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  int'(seq_busy), 0);
        chk({tag, "_done"},  int'(seq_done), 0);
        chk({tag, "_error"}, int'(seq_error), 0);
        chk({tag, "_err"},   int'(err_code), 0);
        chk({tag, "_pc"},    int'(pc), 0);
        chk({tag, "_rd_en"}, int'(bus.instr_rd_en), 0);
        chk({tag, "_starts"}, int'({bus.sys_start, bus.vpu_start, bus.ub_start}), 0);
        chk({tag, "_arg"},   int'(bus.unit_arg), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        int n2;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1) MATMUL, VPU, UBMOVE, HALT with 5-cycle unit latency
        imem[0] = 32'h0400_0011;
        imem[1] = 32'h0800_0022;
        imem[2] = 32'h0C00_0033;
        imem[3] = 32'hFC00_0000;
        resp_en = 1;
        pulse_start(n);
        expect_ev(0, 0, n + 1);
        expect_ev(1, 32'h11, n + 4);
        expect_ev(0, 1, n + 10);
        expect_ev(2, 32'h22, n + 13);
        expect_ev(0, 2, n + 19);
        expect_ev(3, 32'h33, n + 22);
        expect_ev(0, 3, n + 28);
        goto(n + 30);
        chk("t1_busy_issue", int'(seq_busy), 1);
        chk("t1_done_early", int'(seq_done), 0);
        goto(n + 31);
        chk("t1_done", int'(seq_done), 1);
        chk("t1_busy", int'(seq_busy), 0);
        chk("t1_pc", int'(pc), 3);
        chk("t1_err", int'(err_code), 0);
        chk("t1_arg_held", int'(bus.unit_arg), 32'h33);
        resp_en = 0;
        goto(n + 36);

        // 2) NOP, NOP, HALT
        imem[0] = 32'h0000_0000;
        imem[1] = 32'h0000_0000;
        imem[2] = 32'hFC00_0000;
        pulse_start(n);
        chk("t2_done_cleared", int'(seq_done), 0);
        expect_ev(0, 0, n + 1);
        expect_ev(0, 1, n + 4);
        expect_ev(0, 2, n + 7);
        goto(n + 9);
        chk("t2_busy_mid", int'(seq_busy), 1);
        goto(n + 10);
        chk("t2_done", int'(seq_done), 1);
        chk("t2_busy", int'(seq_busy), 0);
        chk("t2_pc", int'(pc), 2);

        // 3) illegal opcode 05
        imem[0] = 32'h1400_0000;
        pulse_start(n);
        expect_ev(0, 0, n + 1);
        goto(n + 4);
        chk("t3_error", int'(seq_error), 1);
        chk("t3_err", int'(err_code), 1);
        chk("t3_busy", int'(seq_busy), 0);
        chk("t3_done", int'(seq_done), 0);
        pulse_start(n2);
        expect_ev(0, 0, n2 + 1);
        chk("t3_error_cleared", int'(seq_error), 0);
        chk("t3_err_cleared", int'(err_code), 0);
        chk("t3_busy_restart", int'(seq_busy), 1);
        goto(n2 + 4);
        chk("t3_err_again", int'(err_code), 1);

        // 4) MATMUL never completes; stray vpu_done ignored; timeout 64 cycles after sys_start
        imem[0] = 32'h0400_0005;
        pulse_start(n);
        expect_ev(0, 0, n + 1);
        expect_ev(1, 5, n + 4);
        goto(n + 20);
        inj_req = inj_req + 1;
        goto(n + 30);
        chk("t4_arg_held", int'(bus.unit_arg), 5);
        chk("t4_busy_wait", int'(seq_busy), 1);
        goto(n + 67);
        chk("t4_err_before", int'(err_code), 0);
        chk("t4_busy_before", int'(seq_busy), 1);
        goto(n + 68);
        chk("t4_err_timeout", int'(err_code), 3);
        chk("t4_error", int'(seq_error), 1);
        chk("t4_busy", int'(seq_busy), 0);

        // 5) 32 NOPs run off the end of IMEM
        for (int i = 0; i < 32; i++) imem[i] = 32'h0000_0000;
        pulse_start(n);
        for (int k = 0; k < 32; k++) expect_ev(0, k, n + 1 + 3 * k);
        goto(n + 96);
        chk("t5_err_before", int'(err_code), 0);
        chk("t5_pc_last", int'(pc), 31);
        goto(n + 97);
        chk("t5_err_pc_end", int'(err_code), 2);
        chk("t5_error", int'(seq_error), 1);
        chk("t5_pc", int'(pc), 31);
        goto(n + 105);

        // 6) reset during WAIT_DONE, then restart from address 0
        imem[0] = 32'h0C00_0077;
        pulse_start(n);
        expect_ev(0, 0, n + 1);
        expect_ev(3, 32'h77, n + 4);
        goto(n + 8);
        chk("t6_busy_wait", int'(seq_busy), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pulse_start(n2);
        expect_ev(0, 0, n2 + 1);
        expect_ev(3, 32'h77, n2 + 4);
        goto(n2 + 6);
        chk("t6_busy_restart", int'(seq_busy), 1);
        chk("t6_pc", int'(pc), 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
